fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types and constants: datapath width, PC step, NOP encoding
// and the {pc, instr} queue entry.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x WIDTH circular FIFO with synchronous flush; the head entry
// is read straight out of the storage registers.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, tracks the one
// outstanding response, and queues {pc, instr} pairs for IF/ID.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            kill;
    logic [CW-1:0]   count;
    logic            accept;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            outstanding;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Reserve a slot for the outstanding response so a full queue never overflows.
    assign imem_req  = !reset && !redirect_valid && ((count + CW'(inflight)) < CW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign rsp       = imem_rvalid && inflight;
    assign push      = rsp && !kill && !redirect_valid;
    assign pop       = out_valid && !stall && !redirect_valid;
    // A request still owed a response after this edge; if redirected it must be dropped.
    assign outstanding = accept || (inflight && !imem_rvalid);

    assign wr_entry  = '{pc: req_pc, instr: imem_rdata};
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= outstanding;
            kill     <= outstanding;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + INSTR_BYTES;
                req_pc   <= fetch_pc;
            end
            if (accept) begin
                inflight <= 1'b1;
            end else if (rsp) begin
                inflight <= 1'b0;
            end
            if (rsp) begin
                kill <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall back-pressure, redirect,
// imem_ready bubbles, PC wrap and mid-run reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;

    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_pc, out_instr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        w_imem_req, w_out_valid;
    logic [31:0] w_imem_addr, w_out_pc, w_out_instr;
    logic        w_imem_rvalid = 1'b0;
    logic [31:0] w_imem_rdata = 32'h0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Memory models: one-cycle response, data = addr ^ A5A5_0000.
    always @(posedge clk) begin
        imem_rvalid <= imem_req && imem_ready;
        imem_rdata  <= imem_addr ^ 32'hA5A5_0000;
    end

    always @(posedge clk) begin
        w_imem_rvalid <= w_imem_req && imem_ready;
        w_imem_rdata  <= w_imem_addr ^ 32'hA5A5_0000;
    end

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(w_out_valid), .out_pc(w_out_pc), .out_instr(w_out_instr)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench sampling in the first cycle after reset deasserts.
    task automatic release_reset(input logic s);
        reset = 1'b1;
        stall = s;
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", imem_req); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h want 00000000", out_pc); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 00000000", out_instr); else passed++;
        total++; if (w_imem_addr !== 32'hFFFF_FFF8) $display("FAIL reset_pc_param: got %h want fffffff8", w_imem_addr); else passed++;
    endtask

    task automatic test_stream;
        logic [31:0] e;
        release_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k))
                $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
            else passed++;
            if (k < 2) begin
                total++; if (out_valid !== 1'b0) $display("FAIL stream_latency c%0d: got out_valid=%b want 0", k, out_valid); else passed++;
            end else begin
                e = 32'(4 * (k - 2));
                total++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== (e ^ 32'hA5A5_0000))
                    $display("FAIL stream_out c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                             k, out_valid, out_pc, out_instr, e, e ^ 32'hA5A5_0000);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_stall;
        release_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA5A5_0000)
                    $display("FAIL stall_head c%0d: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=a5a50000",
                             k, out_valid, out_pc, out_instr);
                else passed++;
            end
            if (k >= 4) begin
                total++; if (imem_req !== 1'b0) $display("FAIL stall_full_req c%0d: got %b want 0", k, imem_req); else passed++;
            end
            if (k == 5) stall = 1'b0;
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (j + 1)))
                $display("FAIL stall_drain %0d: got v=%b pc=%h want v=1 pc=%h", j, out_valid, out_pc, 32'(4 * (j + 1)));
            else passed++;
            tick();
        end
    endtask

    // Runs straight after test_stall, with a response in flight in the redirect cycle.
    task automatic test_redirect;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1002;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL redirect_req_blocked: got %b want 0", imem_req); else passed++;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL redirect_flush: got out_valid=%b want 0", out_valid); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000)
            $display("FAIL redirect_new_req: got req=%b addr=%h want req=1 addr=00001000", imem_req, imem_addr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0000_1004)
            $display("FAIL redirect_drop: got v=%b addr=%h want v=0 addr=00001004", out_valid, imem_addr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1000 || out_instr !== 32'hA5A5_1000)
            $display("FAIL redirect_first: got v=%b pc=%h instr=%h want v=1 pc=00001000 instr=a5a51000", out_valid, out_pc, out_instr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1004)
            $display("FAIL redirect_second: got v=%b pc=%h want v=1 pc=00001004", out_valid, out_pc);
        else passed++;
    endtask

    task automatic test_ready_toggle;
        logic [31:0] e;
        logic [31:0] ew;
        int n;
        int nw;
        logic want_v;
        e = 32'h0;
        ew = 32'hFFFF_FFF8;
        n = 0;
        nw = 0;
        release_reset(1'b0);
        for (int k = 0; k < 12; k++) begin
            imem_ready = (k % 2 == 0);
            #1;
            want_v = (k >= 2) && (k % 2 == 0);
            total++; if (out_valid !== want_v) $display("FAIL toggle_bubble c%0d: got %b want %b", k, out_valid, want_v); else passed++;
            if (out_valid === 1'b1) begin
                total++; if (out_pc !== e) $display("FAIL toggle_seq c%0d: got %h want %h", k, out_pc, e); else passed++;
                e = e + 32'd4;
                n++;
            end
            if (w_out_valid === 1'b1) begin
                total++; if (w_out_pc !== ew) $display("FAIL wrap_seq c%0d: got %h want %h", k, w_out_pc, ew); else passed++;
                ew = ew + 32'd4;
                nw++;
            end
            tick();
        end
        imem_ready = 1'b1;
        total++; if (n != 5) $display("FAIL toggle_count: got %0d want 5", n); else passed++;
        total++; if (nw != 5) $display("FAIL wrap_count: got %0d want 5", nw); else passed++;
    endtask

    task automatic test_reset_mid;
        release_reset(1'b1);
        for (int k = 0; k < 4; k++) tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_req !== 1'b0)
            $display("FAIL midrst_pre: got v=%b pc=%h req=%b want v=1 pc=00000000 req=0", out_valid, out_pc, imem_req);
        else passed++;
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL midrst_clear: got v=%b req=%b want v=0 req=0", out_valid, imem_req);
        else passed++;
        reset = 1'b0;
        stall = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL midrst_refetch: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_empty: got %b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA5A5_0000)
            $display("FAIL midrst_first: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=a5a50000", out_valid, out_pc, out_instr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h4)
            $display("FAIL midrst_second: got v=%b pc=%h want v=1 pc=00000004", out_valid, out_pc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ready_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
